// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and helpers for the load/store initiator.
//                size_t       - access size encoding (shared by request
//                               and RAM sides)
//                lsu_state_t  - initiator state encoding
//                is_misaligned - true for half/word not on a natural boundary
//                access_count  - number of byte-serial accesses N for a size
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            HALF:    r = addr_lo[0];
            WORD:    r = (addr_lo != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] access_count(input size_t size);
        logic [2:0] n;
        case (size)
            HALF:    n = 3'd2;
            WORD:    n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_extend.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_extend
//  Description : Combinational sign/zero extension of a right-aligned
//                byte, half or word to DATA_WIDTH.
//  Ports       : i_data  - right-aligned raw load data
//                i_size  - access size (byte/half/word)
//                i_zext  - 1 = zero-extend, 0 = sign-extend
//                o_data  - extended result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  size_t                 i_size,
    input  logic                  i_zext,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic w_bsign;
    logic w_hsign;

    assign w_bsign = i_data[7]  & ~i_zext;
    assign w_hsign = i_data[15] & ~i_zext;

    always_comb begin
        o_data = i_data;
        case (i_size)
            BYTE:    o_data = {{(DATA_WIDTH-8){w_bsign}},  i_data[7:0]};
            HALF:    o_data = {{(DATA_WIDTH-16){w_hsign}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule : lsu_extend
`default_nettype wire

// File: rtl/lsu_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_initiator
//  Description : Load/store initiator between the execute stage and a
//                byte-addressed data RAM. Accepts one request at a time
//                (valid/ready), performs one RAM access (or N byte-serial
//                accesses for misaligned requests) and returns a one-cycle
//                response with extended load data or an error flag.
//  Config      : LSU_MISALIGN_EN - when defined, misaligned half/word
//                requests are split into byte accesses; otherwise they are
//                rejected with rsp_err.
//  Ports       : clk, rst (async, active-high)
//                req_*  - request handshake and fields
//                rsp_*  - completion pulse, load data, error
//                mem_*  - RAM write-enable, size, address, write/read data
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_initiator
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_err,
    output logic                     mem_WE,
    output logic [1:0]               mem_dataType,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0]    mem_WD,
    input  logic [DATA_WIDTH-1:0]    mem_RD
);

    lsu_state_t                r_state;
    lsu_state_t                w_next_state;
    logic                      r_we;
    size_t                     r_size;
    logic                      r_unsigned;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_err;
    logic [DATA_WIDTH-1:0]     w_ext;
    logic                      w_accept;
    logic                      w_reject;
    logic                      w_last;
    size_t                     w_req_size;

    assign w_req_size = size_t'(req_size);

    // Ready is gated by rst so it reads 0 for the whole reset interval,
    // not just after the first clock.
    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

`ifdef LSU_MISALIGN_EN
    logic [1:0] r_cnt;
    logic       r_misal;

    assign w_reject = (w_req_size == RSVD);
    assign w_last   = !r_misal || ({1'b0, r_cnt} == (access_count(r_size) - 3'd1));
`else
    assign w_reject = (w_req_size == RSVD) || is_misaligned(w_req_size, req_addr[1:0]);
    assign w_last   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_reject ? RESP : ACCESS;
            ACCESS:  if (w_last)   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM-side outputs: only driven during ACCESS, zero otherwise
    // ------------------------------------------------------------------
    always_comb begin
        mem_WE       = 1'b0;
        mem_dataType = 2'b00;
        mem_A        = '0;
        mem_WD       = '0;
        if (r_state == ACCESS) begin
            mem_WE       = r_we;
            mem_dataType = r_size;
            mem_A        = r_addr;
            mem_WD       = r_wdata;
`ifdef LSU_MISALIGN_EN
            if (r_misal) begin
                mem_dataType = BYTE;
                mem_A        = r_addr + ADDRESS_WIDTH'(r_cnt);
                mem_WD       = DATA_WIDTH'(r_wdata[{r_cnt, 3'b000} +: 8]);
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_size     <= BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
`ifdef LSU_MISALIGN_EN
            r_cnt      <= 2'd0;
            r_misal    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_reject;
`ifdef LSU_MISALIGN_EN
                        r_cnt      <= 2'd0;
                        r_misal    <= is_misaligned(w_req_size, req_addr[1:0]);
`endif
                    end
                end
                ACCESS: begin
`ifdef LSU_MISALIGN_EN
                    r_cnt <= r_cnt + 2'd1;
                    if (!r_we) begin
                        // Misaligned loads assemble little-endian, one byte
                        // lane per access.
                        if (r_misal) r_rdata[{r_cnt, 3'b000} +: 8] <= mem_RD[7:0];
                        else         r_rdata <= mem_RD;
                    end
`else
                    if (!r_we) r_rdata <= mem_RD;
`endif
                end
                default: ;
            endcase
        end
    end

    lsu_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extend (
        .i_data (r_rdata),
        .i_size (r_size),
        .i_zext (r_unsigned),
        .o_data (w_ext)
    );

    // ------------------------------------------------------------------
    // Response outputs
    // ------------------------------------------------------------------
    assign rsp_valid = (r_state == RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_data  = (rsp_valid && !r_we && !r_err) ? w_ext : '0;

endmodule : lsu_initiator
`default_nettype wire

// File: tb/tb_lsu_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_initiator
//  Description : Directed self-checking bench for lsu_initiator with a
//                256-byte little-endian RAM model. Honours LSU_MISALIGN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_WE;
    logic [1:0]  mem_dataType;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    bit   [7:0]  mem [256];
    int          we_cnt;
    int          rsp_cnt;
    int          n_checks;
    int          n_errors;

    lsu_initiator #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mem_WE       (mem_WE),
        .mem_dataType (mem_dataType),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_RD       (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge.
    logic [7:0] ra;
    always_comb begin
        ra     = mem_A[7:0];
        mem_RD = 32'h0;
        case (mem_dataType)
            2'b00:   mem_RD = {24'h0, mem[ra]};
            2'b01:   mem_RD = {16'h0, mem[ra + 8'd1], mem[ra]};
            default: mem_RD = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_WE) begin
            we_cnt = we_cnt + 1;
            mem[ra] <= mem_WD[7:0];
            if (mem_dataType != 2'b00) mem[ra + 8'd1] <= mem_WD[15:8];
            if (mem_dataType == 2'b10) begin
                mem[ra + 8'd2] <= mem_WD[23:16];
                mem[ra + 8'd3] <= mem_WD[31:24];
            end
        end
        if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for rsp_valid, return data/err/
    // latency in edges from handshake and number of write cycles seen.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int writes);
        int w0;
        @(negedge clk);
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        w0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'h0, 32'h1);
        rd = rsp_data;
        er = rsp_err;
        @(posedge clk);
        #1;
        writes = we_cnt - w0;
        check("ready_after_resp", {31'h0, req_ready}, 32'h1);
        check("rsp_valid_one_cycle", {31'h0, rsp_valid}, 32'h0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wr;
    int          rbase;

    initial begin
        n_checks = 0; n_errors = 0; we_cnt = 0; rsp_cnt = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        #2;
        check("rst_ready",     {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_data",  rsp_data,           32'h0);
        check("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
        check("rst_mem_we",    {31'h0, mem_WE},    32'h0);
        check("rst_mem_a",     mem_A,              32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Aligned word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, wr);
        check("st_w_lat", lat, 2);
        check("st_w_err", {31'h0, er}, 32'h0);
        check("st_w_writes", wr, 1);
        check("st_w_rdata", rd, 32'h0);
        check("st_w_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, wr);
        check("ld_w_lat", lat, 2);
        check("ld_w_data", rd, 32'hDEADBEEF);
        check("ld_w_writes", wr, 0);

        // Byte 0x80 at 0x21, half 0xA5A5 at 0x22
        do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80, rd, er, lat, wr);
        check("st_b_mem", {24'h0, mem[8'h21]}, 32'h80);
        check("st_b_neighbour", {24'h0, mem[8'h22]}, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000A5A5, rd, er, lat, wr);
        check("st_h_mem", {16'h0, mem[8'h23], mem[8'h22]}, 32'hA5A5);
        do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, er, lat, wr);
        check("ld_b_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd, er, lat, wr);
        check("ld_b_unsigned", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat, wr);
        check("ld_h_signed", rd, 32'hFFFFA5A5);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat, wr);
        check("ld_h_unsigned", rd, 32'h0000A5A5);
        check("ld_h_lat", lat, 2);

        // Reserved size
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h12345678, rd, er, lat, wr);
        check("rsvd_err", {31'h0, er}, 32'h1);
        check("rsvd_lat", lat, 1);
        check("rsvd_writes", wr, 0);
        check("rsvd_data", rd, 32'h0);

`ifdef LSU_MISALIGN_EN
        do_req(1'b1, 2'b10, 1'b0, 32'h31, 32'h11223344, rd, er, lat, wr);
        check("mis_st_lat", lat, 5);
        check("mis_st_writes", wr, 4);
        check("mis_st_err", {31'h0, er}, 32'h0);
        check("mis_st_mem", {mem[8'h34], mem[8'h33], mem[8'h32], mem[8'h31]}, 32'h11223344);
        do_req(1'b0, 2'b10, 1'b0, 32'h31, 32'h0, rd, er, lat, wr);
        check("mis_ld_lat", lat, 5);
        check("mis_ld_data", rd, 32'h11223344);
        do_req(1'b0, 2'b01, 1'b0, 32'h33, 32'h0, rd, er, lat, wr);
        check("mis_ld_h_lat", lat, 3);
        check("mis_ld_h_data", rd, 32'h00001122);
`else
        do_req(1'b1, 2'b10, 1'b0, 32'h02, 32'h11223344, rd, er, lat, wr);
        check("mis_err", {31'h0, er}, 32'h1);
        check("mis_lat", lat, 1);
        check("mis_writes", wr, 0);
        check("mis_mem", {mem[8'h05], mem[8'h04], mem[8'h03], mem[8'h02]}, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, rd, er, lat, wr);
        check("mis_h_err", {31'h0, er}, 32'h1);
`endif

        // Reset during an access
        @(negedge clk);
        rbase = rsp_cnt;
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
`ifdef LSU_MISALIGN_EN
        req_addr = 32'h51;
`else
        req_addr = 32'h50;
`endif
        req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
`ifdef LSU_MISALIGN_EN
        @(posedge clk);
        #1;
        check("midrst_k1_addr", mem_A, 32'h52);
`else
        check("midrst_access_we", {31'h0, mem_WE}, 32'h1);
`endif
        rst = 1'b1;
        #1;
        check("midrst_mem_we", {31'h0, mem_WE}, 32'h0);
        check("midrst_mem_a",  mem_A,  32'h0);
        check("midrst_mem_wd", mem_WD, 32'h0);
        check("midrst_ready",  {31'h0, req_ready}, 32'h0);
        check("midrst_rsp",    {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_release", {31'h0, req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_rsp", rsp_cnt - rbase, 0);
`ifdef LSU_MISALIGN_EN
        check("midrst_partial_kept", {24'h0, mem[8'h51]}, 32'h0D);
        check("midrst_k1_not_written", {24'h0, mem[8'h52]}, 32'h0);
`else
        check("midrst_no_write", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h0);
`endif

        // Block still usable after the abort
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, wr);
        check("post_rst_ld", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lsu_initiator
`default_nettype wire

// File: doc/lsu_initiator.md
# lsu_initiator

Load/store initiator that sits between the execute stage and the byte-addressed data RAM. It accepts one load or store request at a time over a valid/ready handshake and drives the RAM's write-enable, data-type, address and write-data lines. For loads it captures the RAM read data, then sign- or zero-extends it. When enabled, it splits misaligned accesses into byte-serial RAM accesses.

## Interface
- `ADDRESS_WIDTH`, 32: RAM address width.
- `DATA_WIDTH`, 32: data width; fixed at 32 for byte-lane logic.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. High only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: zero-extend the load result; 0 sign-extends.
- `req_addr` in ADDRESS_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned.
- `rsp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `rsp_data` out DATA_WIDTH: extended load data. 0 for stores.
- `rsp_err` out 1: request rejected. Qualified by `rsp_valid`.
- `mem_WE` out 1: RAM write enable.
- `mem_dataType` out 2: RAM access size, same encoding as `req_size`.
- `mem_A` out ADDRESS_WIDTH: RAM address.
- `mem_WD` out DATA_WIDTH: RAM write data, right-aligned.
- `mem_RD` in DATA_WIDTH: RAM read data, combinational from `mem_A`/`mem_dataType`.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - On `req_valid && req_ready`, register all request fields.
  - Load the byte counter with 0 and go to ACCESS.
  - If the request is rejected, go directly to RESP with `rsp_err`=1.
- **Aligned request:** byte, half at even address, or word at address%4==0.
  - One ACCESS cycle with `mem_A`=addr, `mem_dataType`=size, `mem_WE`=we, `mem_WD`=wdata.
  - For loads, capture `mem_RD` at the end of ACCESS.
- **Misaligned request** (with LSU_MISALIGN_EN):
  - N byte accesses, N=2 for half, 4 for word, in ACCESS cycles k=0..N-1.
  - Access k uses `mem_A`=addr+k (wraps modulo 2^ADDRESS_WIDTH), `mem_dataType`=00, `mem_WD`=wdata[8k+7:8k].
  - Loads assemble `mem_RD[7:0]` into byte k of the capture register (little-endian).
- **ACCESS exit:** go to RESP after the last access.
- **RESP:**
  - `rsp_valid`=1 for one cycle.
  - `rsp_data` = captured data extended per size and `req_unsigned`.
  - Return to IDLE.
- **Error cases:**
  - `req_size`=11 always sets `rsp_err`=1, with no RAM access.
  - A store never drives `mem_WE` on an error path.
- **Idle outputs:** outside ACCESS, `mem_WE`=0 and `mem_A`/`mem_WD`/`mem_dataType` hold 0.

## Timing
- **Reset:** state=IDLE, counter=0, all registers 0.
- **Outputs during reset:**
  - `req_ready`=0 while `rst` is high.
  - `req_ready`=1 from the first cycle after release.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_WE`=0.
- **Latency,** handshake edge to `rsp_valid` cycle:
  - Aligned: 2 cycles.
  - Misaligned: N+1 cycles.
  - Error: 1 cycle.
- **Throughput:** next request accepted one cycle after RESP, i.e. `req_ready` rises in the cycle after the `rsp_valid` pulse.
- **Request fields:** ignored whenever `req_ready`=0; no back-to-back acceptance.
- **Reset mid-operation:**
  - Abort immediately.
  - Partially completed misaligned stores are not rolled back.
  - No `rsp_valid` is issued.

## Configuration
- **`LSU_MISALIGN_EN` defined:** misaligned half/word requests are split byte-serially as above.
- **`LSU_MISALIGN_EN` undefined:**
  - A misaligned request goes IDLE→RESP with `rsp_err`=1 and no RAM access.
  - The byte counter logic is compiled out.

## Structure
- **Package `lsu_pkg`:**
  - `size_t` enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10, RSVD=2'b11.
  - `lsu_state_t` enum: IDLE, ACCESS, RESP.
  - Misalignment predicate function.
  - Access-count function returning N.
- **Sub-module `lsu_extend`:** combinational sign/zero extension of byte/half/word to DATA_WIDTH.

## Test plan
- **Aligned word store then load:**
  - Store 0xDEADBEEF at 0x10: one ACCESS cycle with `mem_WE`=1.
  - Load word from 0x10: `rsp_data`=0xDEADBEEF two cycles after the handshake.
- **Byte load sign/zero extension:** memory byte 0x80 at 0x21.
  - Signed load gives 0xFFFFFF80.
  - Unsigned load gives 0x00000080.
- **Half load at 0x22:**
  - Memory 0xA5A5 gives 0xFFFFA5A5 signed.
  - Same location gives 0x0000A5A5 unsigned.
- **Misaligned word store 0x11223344 at 0x31 (macro on):**
  - Four byte writes: 0x44@0x31, 0x33@0x32, 0x22@0x33, 0x11@0x34.
  - Word load from 0x31 returns 0x11223344 with 5-cycle latency.
- **Error paths:**
  - `req_size`=11 gives `rsp_err`=1 one cycle after the handshake, with `mem_WE` never high.
  - With the macro off, a word store at 0x02 also gives `rsp_err`=1 and no write.
- **Mid-transfer reset:**
  - Assert `rst` during access k=1 of a misaligned word store.
  - Outputs return to reset values immediately and no `rsp_valid` is issued.
  - `req_ready`=1 in the first cycle after release.
